// File: rtl/regfile_sb.sv
// Two-read/two-write register file with a busy scoreboard for pending producers.
// Optional same-cycle write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en_0,
  input  logic [ADDR_W-1:0]          rd_addr_0,
  output logic [DATA_W-1:0]          rd_data_0,
  output logic                       rd_busy_0,
  input  logic                       rd_en_1,
  input  logic [ADDR_W-1:0]          rd_addr_1,
  output logic [DATA_W-1:0]          rd_data_1,
  output logic                       rd_busy_1,
  input  logic                       wr_en_0,
  input  logic [ADDR_W-1:0]          wr_addr_0,
  input  logic [DATA_W-1:0]          wr_data_0,
  input  logic                       wr_en_1,
  input  logic [ADDR_W-1:0]          wr_addr_1,
  input  logic [DATA_W-1:0]          wr_data_1,
  input  logic                       res_en,
  input  logic [ADDR_W-1:0]          res_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  logic                wr_ok_0, wr_ok_1, res_ok;

  logic [1:0]          rd_en_a;
  logic [ADDR_W-1:0]   rd_addr_a [2];
  logic [DATA_W-1:0]   rd_data_a [2];
  logic [1:0]          rd_busy_a;

  assign wr_ok_0 = wr_en_0 && (wr_addr_0 != '0);
  assign wr_ok_1 = wr_en_1 && (wr_addr_1 != '0);
  assign res_ok  = res_en  && (res_addr  != '0);

  // Writes retire producers first; a reserve at the same edge re-arms the bit.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_ok_0) busy_nxt[wr_addr_0] = 1'b0;
    if (wr_ok_1) busy_nxt[wr_addr_1] = 1'b0;
    if (res_ok)  busy_nxt[res_addr]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  // Storage and scoreboard; port 1 is written last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok_0) mem[wr_addr_0] <= wr_data_0;
      if (wr_ok_1) mem[wr_addr_1] <= wr_data_1;
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign rd_en_a[0]   = rd_en_0;
  assign rd_en_a[1]   = rd_en_1;
  assign rd_addr_a[0] = rd_addr_0;
  assign rd_addr_a[1] = rd_addr_1;

  // Combinational read ports; register 0 and disabled ports return zero.
  always_comb begin
    rd_data_a = '{default: '0};
    rd_busy_a = '0;
    for (int k = 0; k < 2; k++) begin
      if (!rst && rd_en_a[k] && (rd_addr_a[k] != '0)) begin
        rd_data_a[k] = mem[rd_addr_a[k]];
        rd_busy_a[k] = busy_vec[rd_addr_a[k]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_1 && (wr_addr_1 == rd_addr_a[k])) begin
          rd_data_a[k] = wr_data_1;
          rd_busy_a[k] = res_en && (res_addr == rd_addr_a[k]);
        end else if (wr_en_0 && (wr_addr_0 == rd_addr_a[k])) begin
          rd_data_a[k] = wr_data_0;
          rd_busy_a[k] = res_en && (res_addr == rd_addr_a[k]);
        end
`endif
      end
    end
  end

  assign rd_data_0 = rd_data_a[0];
  assign rd_data_1 = rd_data_a[1];
  assign rd_busy_0 = rd_busy_a[0];
  assign rd_busy_1 = rd_busy_a[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table plus scoreboard/reset sequences.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en_0, rd_en_1;
  logic [4:0]  rd_addr_0, rd_addr_1;
  logic [31:0] rd_data_0, rd_data_1;
  logic        rd_busy_0, rd_busy_1;
  logic        wr_en_0, wr_en_1;
  logic [4:0]  wr_addr_0, wr_addr_1;
  logic [31:0] wr_data_0, wr_data_1;
  logic        res_en;
  logic [4:0]  res_addr;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .rd_en_0(rd_en_0), .rd_addr_0(rd_addr_0), .rd_data_0(rd_data_0), .rd_busy_0(rd_busy_0),
    .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_busy_1(rd_busy_1),
    .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .res_en(res_en), .res_addr(res_addr),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  // Inputs for one cycle and the outputs expected during that cycle (before its edge).
  typedef struct {
    logic        rst;
    logic        re0; logic [4:0] ra0;
    logic        re1; logic [4:0] ra1;
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        res; logic [4:0] rsa;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_b0;  logic        e_b1;
    logic [31:0] e_vec; logic [5:0]  e_cnt;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    rst = v.rst;
    rd_en_0 = v.re0; rd_addr_0 = v.ra0; rd_en_1 = v.re1; rd_addr_1 = v.ra1;
    wr_en_0 = v.we0; wr_addr_0 = v.wa0; wr_data_0 = v.wd0;
    wr_en_1 = v.we1; wr_addr_1 = v.wa1; wr_data_1 = v.wd1;
    res_en = v.res; res_addr = v.rsa;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, " rd_data_0"}, rd_data_0, e.e_rd0);
    chk({tag, " rd_data_1"}, rd_data_1, e.e_rd1);
    chk({tag, " rd_busy_0"}, {31'd0, rd_busy_0}, {31'd0, e.e_b0});
    chk({tag, " rd_busy_1"}, {31'd0, rd_busy_1}, {31'd0, e.e_b1});
    chk({tag, " busy_vec"}, busy_vec, e.e_vec);
    chk({tag, " busy_cnt"}, {26'd0, busy_cnt}, {26'd0, e.e_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [31:0] model_vec;

    // order: rst, re0,ra0, re1,ra1, we0,wa0,wd0, we1,wa1,wd1, res,rsa, e_rd0,e_rd1, e_b0,e_b1, e_vec,e_cnt
    tbl[0] = '{1'b1, 1'b1,5'd5, 1'b1,5'd7, 1'b1,5'd5,32'hFFFF_FFFF, 1'b0,5'd0,32'h0, 1'b1,5'd6,
               32'h0, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[1] = '{1'b0, 1'b1,5'd6, 1'b1,5'd7, 1'b1,5'd5,32'h1234_5678, 1'b0,5'd0,32'h0, 1'b0,5'd0,
               32'h0, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[2] = '{1'b0, 1'b1,5'd5, 1'b1,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd0,32'hDEAD_BEEF, 1'b1,5'd0,
               32'h1234_5678, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[3] = '{1'b0, 1'b0,5'd5, 1'b1,5'd0, 1'b1,5'd7,32'hA, 1'b1,5'd7,32'hB, 1'b0,5'd0,
               32'h0, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[4] = '{1'b0, 1'b1,5'd7, 1'b1,5'd7, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd3,
               32'hB, 32'hB, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[5] = '{1'b0, 1'b1,5'd3, 1'b0,5'd3, 1'b1,5'd3,32'h33, 1'b0,5'd0,32'h0, 1'b0,5'd0,
               (BYP ? 32'h33 : 32'h0), 32'h0, !BYP,1'b0, 32'h8, 6'd1};
    tbl[6] = '{1'b0, 1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd4,32'h44, 1'b1,5'd4,
               32'h33, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    tbl[7] = '{1'b0, 1'b0,5'd0, 1'b1,5'd4, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd4,
               32'h0, 32'h44, 1'b0,1'b1, 32'h10, 6'd1};
    tbl[8] = '{1'b0, 1'b1,5'd4, 1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,
               32'h44, 32'h0, 1'b1,1'b0, 32'h10, 6'd1};

    rst = 1'b1;
    rd_en_0 = 1'b0; rd_addr_0 = '0; rd_en_1 = 1'b0; rd_addr_1 = '0;
    wr_en_0 = 1'b0; wr_addr_0 = '0; wr_data_0 = '0;
    wr_en_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0;
    res_en = 1'b0; res_addr = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Reserve every nonzero register; r4 is already busy so it must not double count.
    model_vec = 32'h10;
    for (int i = 1; i < 32; i++) begin
      v = '{1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'(i),
            32'h0, 32'h0, 1'b0,1'b0, model_vec, 6'($countones(model_vec))};
      step($sformatf("res%0d", i), v);
      model_vec[i] = 1'b1;
    end
    v = '{1'b0, 1'b1,5'd4, 1'b1,5'd5, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,
          32'h44, 32'h1234_5678, 1'b1,1'b1, 32'hFFFF_FFFE, 6'd31};
    step("full", v);

    // Two writes retire two producers in one edge; reserving a busy r9 adds nothing.
    v = '{1'b0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd1,32'h11, 1'b1,5'd2,32'h22, 1'b1,5'd9,
          32'h0, 32'h0, 1'b0,1'b0, 32'hFFFF_FFFE, 6'd31};
    step("dec2_a", v);
    v = '{1'b0, 1'b1,5'd1, 1'b1,5'd2, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,
          32'h11, 32'h22, 1'b0,1'b0, 32'hFFFF_FFF8, 6'd29};
    step("dec2_b", v);

    // Reset mid-stream with a write and reserve pending.
    v = '{1'b1, 1'b1,5'd5, 1'b1,5'd4, 1'b1,5'd10,32'h99, 1'b0,5'd0,32'h0, 1'b1,5'd1,
          32'h0, 32'h0, 1'b0,1'b0, 32'hFFFF_FFF8, 6'd29};
    step("rst_a", v);
    v = '{1'b0, 1'b1,5'd5, 1'b1,5'd7, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,
          32'h0, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    step("rst_b", v);
    v = '{1'b0, 1'b1,5'd10, 1'b1,5'd1, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,
          32'h0, 32'h0, 1'b0,1'b0, 32'h0, 6'd0};
    step("rst_c", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports rd_en_0/rd_en_1  input  1  read enable, per read port.
REQ-006 The block SHALL have ports rd_addr_0/rd_addr_1  input  ADDR_W  read address.
REQ-007 The block SHALL have ports rd_data_0/rd_data_1  output  DATA_W  read data, combinational.
REQ-008 The block SHALL have ports rd_busy_0/rd_busy_1  output  1  read register has a pending producer.
REQ-009 The block SHALL have ports wr_en_0/wr_en_1  input  1  write enable, per write port.
REQ-010 The block SHALL have ports wr_addr_0/wr_addr_1  input  ADDR_W  write address.
REQ-011 The block SHALL have ports wr_data_0/wr_data_1  input  DATA_W  write data.
REQ-012 The block SHALL have port res_en  input  1  reserve request (marks destination busy).
REQ-013 The block SHALL have port res_addr  input  ADDR_W  register to reserve.
REQ-014 The block SHALL have port busy_vec  output  NUM_REGS  registered scoreboard, bit i = register i busy.
REQ-015 The block SHALL have port busy_cnt  output  ADDR_W+1  registered population count of busy_vec.

Function
REQ-016 Register 0 SHALL read as 0, ignore writes, never become busy; res_addr=0 and wr_addr=0 SHALL have no effect.
REQ-017 Writes SHALL take effect at the rising edge where wr_en_k=1; both ports writing one address -> port 1 data stored.
REQ-018 Reads SHALL be combinational; rd_en_k=0 -> rd_data_k=0 and rd_busy_k=0.
REQ-019 res_en=1 with res_addr!=0 SHALL set busy[res_addr] at the next edge; reserving an already-busy register leaves it busy, count unchanged.
REQ-020 A write on either port to a nonzero address SHALL clear busy[wr_addr] at the same edge.
REQ-021 Reserve and write to the same address at one edge SHALL leave the register busy (new producer wins) while still storing the write data.
REQ-022 busy_cnt SHALL equal the number of set bits in busy_vec every cycle; at most +1 and -2 per edge, never wrapping.
REQ-023 rd_busy_k SHALL equal busy[rd_addr_k] when rd_en_k=1, subject to REQ-026.

Reset
REQ-024 At a rising edge with rst=1, all registers SHALL clear to 0, busy_vec to 0, busy_cnt to 0; rst overrides writes and reserves at that edge.
REQ-025 While rst=1, rd_data_k and rd_busy_k SHALL be 0.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: a read whose nonzero rd_addr_k matches an enabled write address in the same cycle SHALL return that write data (port 1 priority) and rd_busy_k=0 unless res_en/res_addr also target it; undefined: reads SHALL return stored contents only, new data visible the cycle after the write, rd_busy_k from registered busy_vec.

Verification
REQ-027 rst then write 0x1234_5678 to r5, read r5 next cycle -> rd_data_0=0x12345678, busy_cnt=0.
REQ-028 Write 0xDEAD_BEEF to r0, read r0 -> rd_data_1=0; reserve r0 -> busy_vec=0.
REQ-029 wr_en_0 r7=0xA, wr_en_1 r7=0xB same edge -> r7 reads 0xB.
REQ-030 Reserve r3 -> busy_vec[3]=1, busy_cnt=1; write r3 while reading r3 -> bypass build: rd_data=write data, rd_busy=0 same cycle; non-bypass: old data, rd_busy=1, then new data, busy_cnt=0 next cycle.
REQ-031 Reserve r4 and write r4 same edge -> busy_vec[4]=1, r4 holds written data; reserve all 31 nonzero registers -> busy_cnt=31.
REQ-032 Assert rst mid-sequence with writes and reserve pending -> next cycle all reads 0, busy_vec=0, busy_cnt=0.
